// File: rtl/alarm_controller_pkg.sv
// Shared types and constants for the alarm controller slice.
package alarm_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_e;

  localparam logic [7:0] HOUR_MIN = 8'h01;
  localparam logic [7:0] HOUR_MAX = 8'h12;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  localparam logic [7:0] RST_ALARM_HH = 8'h12;
  localparam logic [7:0] RST_ALARM_MM = 8'h00;
  localparam logic       RST_ALARM_PM = 1'b0;

  // Both nibbles must be decimal digits; once they are, a plain binary
  // compare orders packed BCD correctly, so the upper bound is a single compare.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/alarm_controller_time_reg.sv
// Alarm time storage: validates set requests, loads valid ones, pulses set_err on invalid ones.
module alarm_time_reg
  import alarm_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  output logic       set_load,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       alarm_pm,
  output logic       set_err
);

  logic       time_ok;
  logic [7:0] alarm_hh_d, alarm_hh_q;
  logic [7:0] alarm_mm_d, alarm_mm_q;
  logic       alarm_pm_d, alarm_pm_q;
  logic       set_err_d,  set_err_q;

  // Validate the requested time and compute next register contents.
  always_comb begin
    time_ok    = bcd_valid(set_hh, HOUR_MAX) && (set_hh >= HOUR_MIN) &&
                 bcd_valid(set_mm, MIN_MAX);
    set_load   = set_valid && time_ok;
    set_err_d  = set_valid && !time_ok;
    alarm_hh_d = alarm_hh_q;
    alarm_mm_d = alarm_mm_q;
    alarm_pm_d = alarm_pm_q;
    if (set_load) begin
      alarm_hh_d = set_hh;
      alarm_mm_d = set_mm;
      alarm_pm_d = set_pm;
    end
  end

  // Alarm registers and error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_hh_q <= RST_ALARM_HH;
      alarm_mm_q <= RST_ALARM_MM;
      alarm_pm_q <= RST_ALARM_PM;
      set_err_q  <= 1'b0;
    end else begin
      alarm_hh_q <= alarm_hh_d;
      alarm_mm_q <= alarm_mm_d;
      alarm_pm_q <= alarm_pm_d;
      set_err_q  <= set_err_d;
    end
  end

  assign alarm_hh = alarm_hh_q;
  assign alarm_mm = alarm_mm_q;
  assign alarm_pm = alarm_pm_q;
  assign set_err  = set_err_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: match detection against the running time plus ring/snooze/dismiss FSM.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic       alarm_en,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       alarm_pm,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snoozes_left,
  output logic       set_err
);

  localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int unsigned RING_W    = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam int unsigned SNZ_W     = (SNZ_TICKS > 1) ? $clog2(SNZ_TICKS) : 1;
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNZ_TICKS - 1);
  localparam logic [2:0]        SNZ_MAX   = 3'(MAX_SNOOZE);

  state_e            state_d, state_q;
  logic [RING_W-1:0] ring_cnt_d, ring_cnt_q;
  logic [SNZ_W-1:0]  snz_cnt_d, snz_cnt_q;
  logic [2:0]        snoozes_left_d, snoozes_left_q;
  logic              match_d, match_q;
  logic              ringing_d, ringing_q;
  logic              snoozing_d, snoozing_q;
  logic              trigger;
  logic              set_load;

  alarm_time_reg u_time_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_valid (set_valid),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_pm    (set_pm),
    .set_load  (set_load),
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_pm  (alarm_pm),
    .set_err   (set_err)
  );

  // Match against the stored alarm; only the rising edge of a match triggers.
  always_comb begin
    match_d = (hh == alarm_hh) && (mm == alarm_mm) && (pm == alarm_pm) && (ss == 8'h00);
    trigger = match_d && !match_q;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      ring_cnt_q     <= '0;
      snz_cnt_q      <= '0;
      snoozes_left_q <= SNZ_MAX;
      match_q        <= 1'b0;
      ringing_q      <= 1'b0;
      snoozing_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      snz_cnt_q      <= snz_cnt_d;
      snoozes_left_q <= snoozes_left_d;
      match_q        <= match_d;
      ringing_q      <= ringing_d;
      snoozing_q     <= snoozing_d;
    end
  end

  // Next-state and counter logic; disable beats a set load, which beats in-state events.
  always_comb begin
    state_d        = state_q;
    ring_cnt_d     = ring_cnt_q;
    snz_cnt_d      = snz_cnt_q;
    snoozes_left_d = snoozes_left_q;
    if (!alarm_en) begin
      state_d = ST_IDLE;
    end else if (set_load && (state_q == ST_RINGING || state_q == ST_SNOOZE)) begin
      // Also covers a simultaneous dismiss: both lead to ARMED with snoozes restored.
      state_d        = ST_ARMED;
      snoozes_left_d = SNZ_MAX;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (trigger) begin
            state_d        = ST_RINGING;
            ring_cnt_d     = '0;
            snoozes_left_d = SNZ_MAX;
          end
        end
        ST_RINGING: begin
          if (dismiss) begin
            state_d        = ST_ARMED;
            snoozes_left_d = SNZ_MAX;
          end else if (snooze && snoozes_left_q != 3'd0) begin
            state_d        = ST_SNOOZE;
            snoozes_left_d = snoozes_left_q - 3'd1;
            snz_cnt_d      = '0;
          end else if (ena) begin
            if (ring_cnt_q == RING_LAST) begin
              state_d        = ST_ARMED;
              snoozes_left_d = SNZ_MAX;
            end else begin
              ring_cnt_d = ring_cnt_q + RING_W'(1);
            end
          end
        end
        ST_SNOOZE: begin
          if (dismiss) begin
            state_d        = ST_ARMED;
            snoozes_left_d = SNZ_MAX;
          end else if (ena) begin
            if (snz_cnt_q == SNZ_LAST) begin
              state_d    = ST_RINGING;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + SNZ_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Indications are decoded from next-state so they land with the state change.
  always_comb begin
    ringing_d  = (state_d == ST_RINGING);
    snoozing_d = (state_d == ST_SNOOZE);
  end

  assign ringing      = ringing_q;
  assign snoozing     = snoozing_q;
  assign snoozes_left = snoozes_left_q;

endmodule
